// File: rtl/linebuffer_pkg.sv
// Shared types and helpers for the activation line buffer.
// The types describe the default build: 256 ternary channels, 5 row slots, 32 columns.
package linebuffer_pkg;

    localparam int LB_N_I        = 256;
    localparam int LB_K_MAX      = 5;
    localparam int LB_IMAGEWIDTH = 32;

    // One pixel: N_I channels of 2 bits each.
    typedef logic [2*LB_N_I-1:0] act_t;

    // One KxK window, indexed [kx][ky].
    typedef act_t [LB_K_MAX-1:0][LB_K_MAX-1:0] window_t;

    // Ring arithmetic on physical row slots.
    function automatic int slot_add(input int slot, input int inc, input int modulus);
        return (slot + inc) % modulus;
    endfunction

endpackage

// File: rtl/linebuffer_row.sv
// One physical row slot of the ring: IMAGEWIDTH pixels with per-column write
// enables and a synchronous clear.
module linebuffer_row
    import linebuffer_pkg::*;
#(
    parameter int N_I        = LB_N_I,
    parameter int IMAGEWIDTH = LB_IMAGEWIDTH
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 flush,
    input  logic [IMAGEWIDTH-1:0]                we,
    input  logic [IMAGEWIDTH-1:0][2*N_I-1:0]     wdata,
    output logic [IMAGEWIDTH-1:0][2*N_I-1:0]     rdata
);

    logic [IMAGEWIDTH-1:0][2*N_I-1:0] mem;

    // Pixel storage: cleared by reset or flush, otherwise written column by column.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem <= '0;
        end else if (flush) begin
            mem <= '0;
        end else begin
            for (int x = 0; x < IMAGEWIDTH; x++) begin
                if (we[x]) begin
                    mem[x] <= wdata[x];
                end
            end
        end
    end

    assign rdata = mem;

endmodule

// File: rtl/linebuffer_ring.sv
// Activation line buffer built as a ring of K_MAX row slots. Lines are written
// by the loader, committed with wr_last_i and retired with release_i; the
// compute array reads zero-padded KxK windows through a registered output stage.
module linebuffer_ring
    import linebuffer_pkg::*;
#(
    parameter int N_I             = LB_N_I,
    parameter int K_MAX           = LB_K_MAX,
    parameter int IMAGEWIDTH      = LB_IMAGEWIDTH,
    parameter int IMAGEHEIGHT     = 32,
    parameter int COLADDRESSWIDTH = $clog2(IMAGEWIDTH),
    parameter int ROWADDRESSWIDTH = $clog2(K_MAX)
) (
    input  logic                                        clk_i,
    input  logic                                        rst_ni,
    input  logic                                        flush_i,
    input  logic [COLADDRESSWIDTH:0]                    layer_imagewidth_i,
    input  logic [ROWADDRESSWIDTH:0]                    layer_k_i,
    input  logic                                        wrap_around_i,
    input  logic                                        wr_valid_i,
    output logic                                        wr_ready_o,
    input  logic [K_MAX-1:0][2*N_I-1:0]                 wr_acts_i,
    input  logic [COLADDRESSWIDTH-1:0]                  wr_col_i,
    input  logic                                        wr_last_i,
    input  logic                                        release_i,
    input  logic                                        rd_valid_i,
    output logic                                        rd_ready_o,
    input  logic [COLADDRESSWIDTH-1:0]                  rd_col_i,
    input  logic [ROWADDRESSWIDTH-1:0]                  rd_row_i,
    output logic [K_MAX-1:0][K_MAX-1:0][2*N_I-1:0]      acts_o,
    output logic                                        acts_valid_o,
    input  logic                                        acts_ready_i
);

    localparam int CW = COLADDRESSWIDTH;
    localparam int RW = ROWADDRESSWIDTH;
    // Signed width wide enough for column/row offsets of +-K_MAX around any address.
    localparam int SW = CW + 3;

    typedef logic [2*N_I-1:0] pix_t;

    // Elaboration-time parameter sanity: the window needs a centre row.
    if ((K_MAX % 2) == 0 || IMAGEHEIGHT < 1) begin : g_bad_params
        $error("linebuffer_ring: K_MAX must be odd and IMAGEHEIGHT positive");
    end

    logic [RW-1:0]                 head;
    logic [RW:0]                   count;
    logic [RW-1:0]                 wr_slot;
    logic [RW:0]                   half;
    logic                          wr_fire;
    logic                          rd_fire;
    logic                          commit;
    logic                          retire;
    logic [IMAGEWIDTH-1:0]         col_we;
    pix_t [IMAGEWIDTH-1:0]         col_wdata;
    logic [K_MAX-1:0][IMAGEWIDTH-1:0] slot_we;
    pix_t [IMAGEWIDTH-1:0]         slot_data [K_MAX];
    pix_t [K_MAX-1:0][K_MAX-1:0]   window;
    pix_t [K_MAX-1:0][K_MAX-1:0]   acts_p1;
    logic                          vld_p1;

    // Handshakes. Writes stall once the ring holds a full kernel of lines.
    assign wr_ready_o = rst_ni && !flush_i && (count < layer_k_i);
    assign wr_fire    = wr_valid_i && wr_ready_o;
    assign commit     = wr_fire && wr_last_i;
    assign retire     = release_i && (count != '0) && !flush_i;
    assign rd_ready_o = !vld_p1 || acts_ready_i;
    assign rd_fire    = rd_valid_i && rd_ready_o && !flush_i;

    // The line being written always sits just past the newest committed line.
    assign wr_slot = RW'(slot_add(int'(head), int'(count), K_MAX));
    assign half    = (layer_k_i - 1'b1) >> 1;

    // Scatter the K_MAX beat pixels onto line columns, wrapping or dropping past the line end.
    always_comb begin
        col_we    = '0;
        col_wdata = '0;
        for (int j = 0; j < K_MAX; j++) begin
            logic [CW:0] c_abs;
            logic [CW:0] tgt;
            logic        tgt_ok;
            c_abs  = (CW+1)'(wr_col_i) + (CW+1)'(j);
            tgt    = c_abs;
            tgt_ok = 1'b1;
            if (c_abs >= layer_imagewidth_i) begin
                if (wrap_around_i) begin
                    tgt = c_abs - layer_imagewidth_i;
                end else begin
                    tgt_ok = 1'b0;
                end
            end
            if (tgt >= (CW+1)'(IMAGEWIDTH)) begin
                tgt_ok = 1'b0;
            end
            if (wr_fire && tgt_ok) begin
                col_we[tgt[CW-1:0]]    = 1'b1;
                col_wdata[tgt[CW-1:0]] = wr_acts_i[j];
            end
        end
    end

    // Route the column enables to the single slot being filled.
    always_comb begin
        slot_we          = '0;
        slot_we[wr_slot] = col_we;
    end

    for (genvar s = 0; s < K_MAX; s++) begin : g_slot
        linebuffer_row #(
            .N_I        (N_I),
            .IMAGEWIDTH (IMAGEWIDTH)
        ) u_row (
            .clk   (clk_i),
            .rst_n (rst_ni),
            .flush (flush_i),
            .we    (slot_we[s]),
            .wdata (col_wdata),
            .rdata (slot_data[s])
        );
    end

    // Window gather with same padding: anything off the line or outside the committed rows reads zero.
    always_comb begin
        window = '0;
        for (int kx = 0; kx < K_MAX; kx++) begin
            for (int ky = 0; ky < K_MAX; ky++) begin
                logic signed [SW-1:0] col_s;
                logic signed [SW-1:0] row_s;
                logic [RW-1:0]        slot;
                col_s = $signed(SW'(rd_col_i)) - $signed(SW'(half)) + $signed(SW'(kx));
                row_s = $signed(SW'(rd_row_i)) - $signed(SW'(half)) + $signed(SW'(ky));
                slot  = RW'(slot_add(int'(head), int'(row_s), K_MAX));
                if (kx < int'(layer_k_i) && ky < int'(layer_k_i) &&
                    col_s >= 0 && col_s < $signed(SW'(layer_imagewidth_i)) &&
                    row_s >= 0 && row_s < $signed(SW'(count))) begin
                    window[kx][ky] = slot_data[slot][col_s[CW-1:0]];
                end
            end
        end
    end

    // Ring pointers: commit grows the occupancy, release retires the oldest line.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head  <= '0;
            count <= '0;
        end else if (flush_i) begin
            head  <= '0;
            count <= '0;
        end else begin
            if (retire) begin
                head <= RW'(slot_add(int'(head), 1, K_MAX));
            end
            count <= count + (RW+1)'(commit) - (RW+1)'(retire);
        end
    end

    // p1: output stage, loads on an accepted request and holds under backpressure.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acts_p1 <= '0;
            vld_p1  <= 1'b0;
        end else if (flush_i) begin
            acts_p1 <= '0;
            vld_p1  <= 1'b0;
        end else if (rd_fire) begin
            acts_p1 <= window;
            vld_p1  <= 1'b1;
        end else if (acts_ready_i) begin
            vld_p1  <= 1'b0;
        end
    end

    assign acts_o       = acts_p1;
    assign acts_valid_o = vld_p1;

endmodule
